idmem_bridge: RTL and testbench

//  Producer of the busy_ok (imem_busy/dmem_busy) bundle that the hazard unit consumes to stall and flush.

---
 rtl/idmem_bridge_pkg.sv | 22 ++
 rtl/idmem_bridge_rsp_hold.sv | 46 ++++
 rtl/idmem_bridge.sv | 147 ++++++++++++++
 tb/tb_idmem_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idmem_bridge_pkg.sv
// Shared types for the IF/MEM-to-bus bridge: the hazard-unit busy bundle,
// the bridge FSM state encoding and the bus access-size codes.
package idmem_bridge_pkg;

    typedef struct packed {
        logic imem_busy;
        logic dmem_busy;
    } busy_ok;

    typedef enum logic [2:0] {
        IDLE,
        D_ADDR,
        D_DATA,
        I_ADDR,
        I_DATA
    } bridge_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/idmem_bridge_rsp_hold.sv
// Response hold register: captures a bus response and keeps it valid until the
// owning pipeline stage advances; the capture cycle bypasses the incoming data.
module rsp_hold #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              set,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        // A stage that advances in the capture cycle consumes the bypassed data.
        if (clr) begin
            valid_d = 1'b0;
        end else if (set) begin
            valid_d = 1'b1;
        end
        if (set && load) begin
            data_d = din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dout  = (set && load) ? din : data_q;
    assign valid = valid_q;

endmodule

// File: rtl/idmem_bridge.sv
// Arbitrates instruction fetches and loads/stores onto one SRAM-like bus,
// one transaction at a time, and reports per-stage busy to the hazard unit.
module idmem_bridge
    import idmem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall_f,
    input  logic              stall_m,
    input  logic              flush_f,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output busy_ok            idmem,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    bridge_state_t     state_q, state_d;
    logic              bus_wr_q, bus_wr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              i_cancel_q, i_cancel_d;

    logic i_hold, d_hold;
    logic i_set, d_set;
    logic d_pend, i_pend;

    assign d_pend = data_req && !d_hold;
    assign i_pend = inst_req && !i_hold && !flush_f;

    // A cancelled fetch still completes on the bus but never reaches IF.
    assign i_set = (state_q == I_DATA) && bus_data_ok && !i_cancel_q;
    assign d_set = (state_q == D_DATA) && bus_data_ok;

    always_comb begin
        state_d     = state_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        i_cancel_d  = i_cancel_q;
        case (state_q)
            IDLE: begin
                if (d_pend) begin
                    state_d     = D_ADDR;
                    bus_wr_d    = data_wr;
                    bus_size_d  = data_size;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                end else if (i_pend) begin
                    state_d     = I_ADDR;
                    bus_wr_d    = 1'b0;
                    bus_size_d  = SIZE_W;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = '0;
                end
            end
            D_ADDR: begin
                if (bus_addr_ok) state_d = D_DATA;
            end
            D_DATA: begin
                if (bus_data_ok) state_d = IDLE;
            end
            I_ADDR: begin
                if (flush_f) i_cancel_d = 1'b1;
                if (bus_addr_ok) state_d = I_DATA;
            end
            I_DATA: begin
                if (bus_data_ok) begin
                    state_d    = IDLE;
                    i_cancel_d = 1'b0;
                end else if (flush_f) begin
                    i_cancel_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= 2'd0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            i_cancel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            i_cancel_q  <= i_cancel_d;
        end
    end

    rsp_hold #(.DATA_W(DATA_W)) u_inst_hold (
        .clk    (clk),
        .resetn (resetn),
        .set    (i_set),
        .load   (1'b1),
        .clr    (!stall_f || flush_f),
        .din    (bus_rdata),
        .dout   (inst_rdata),
        .valid  (i_hold)
    );

    // Store acks mark the access done without touching the load data.
    rsp_hold #(.DATA_W(DATA_W)) u_data_hold (
        .clk    (clk),
        .resetn (resetn),
        .set    (d_set),
        .load   (!bus_wr_q),
        .clr    (!stall_m),
        .din    (bus_rdata),
        .dout   (data_rdata),
        .valid  (d_hold)
    );

    assign idmem.imem_busy = inst_req && !i_hold && !i_set;
    assign idmem.dmem_busy = data_req && !d_hold && !d_set;

    assign bus_req   = (state_q == D_ADDR) || (state_q == I_ADDR);
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_idmem_bridge.sv
// Directed bench for idmem_bridge: table of single transactions plus
// hand-written arbitration, flush, stall and reset sequences.
module tb_idmem_bridge;
    import idmem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall_f = 1'b0, stall_m = 1'b0, flush_f = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic [31:0] data_rdata;
    busy_ok      idmem;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    int          total = 0;
    int          bad = 0;
    int          bursts = 0;
    logic        req_prev = 1'b0;
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;

    always #5 clk = ~clk;

    idmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .stall_f(stall_f), .stall_m(stall_m), .flush_f(flush_f),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .idmem(idmem),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always @(posedge clk) begin
        if (bus_req && !req_prev) bursts++;
        req_prev <= bus_req;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        is_inst;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        int          adly;
        int          ddly;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int idx, input vec_t v);
        int b0;
        @(negedge clk);
        if (v.is_inst) begin
            inst_req = 1'b1; inst_addr = v.addr;
        end else begin
            data_req = 1'b1; data_wr = v.wr; data_size = v.size;
            data_addr = v.addr; data_wdata = v.wdata;
        end
        #1;
        chk("busy_on_req", 32'(v.is_inst ? idmem.imem_busy : idmem.dmem_busy), 32'd1);
        b0 = bursts;
        @(negedge clk); #1;
        chk("bus_req_issue", 32'(bus_req), 32'd1);
        chk("bus_addr", bus_addr, v.addr);
        chk("bus_wr", 32'(bus_wr), 32'(v.wr));
        if (!v.is_inst) begin
            chk("bus_size", 32'(bus_size), 32'(v.size));
            chk("bus_wdata", bus_wdata, v.wdata);
        end
        for (int k = 0; k < v.adly; k++) begin
            @(negedge clk); #1;
            chk("bus_req_held", 32'(bus_req), 32'd1);
            chk("bus_addr_held", bus_addr, v.addr);
        end
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        #1;
        chk("bus_req_after_ok", 32'(bus_req), 32'd0);
        chk("busy_wait", 32'(v.is_inst ? idmem.imem_busy : idmem.dmem_busy), 32'd1);
        for (int k = 0; k < v.ddly; k++) begin
            @(negedge clk); #1;
            chk("busy_wait", 32'(v.is_inst ? idmem.imem_busy : idmem.dmem_busy), 32'd1);
        end
        bus_data_ok = 1'b1; bus_rdata = v.rsp;
        #1;
        chk("busy_drop", 32'(v.is_inst ? idmem.imem_busy : idmem.dmem_busy), 32'd0);
        chk("rdata", v.is_inst ? inst_rdata : data_rdata, v.exp_rdata);
        @(negedge clk);
        bus_data_ok = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
        #1;
        chk("one_burst", 32'(bursts), 32'(b0 + 1));
        $display("txn %0d inst=%0b wr=%0b addr=%h rdata=%h", idx, v.is_inst, v.wr, v.addr, v.exp_rdata);
    endtask

    initial begin
        int b0;
        vecs[0] = '{1'b1, 1'b0, SIZE_W, 32'hBFC00000, 32'h0,        32'h24020001, 2, 2, 32'h24020001};
        vecs[1] = '{1'b0, 1'b0, SIZE_W, 32'h80000010, 32'h0,        32'h11223344, 0, 0, 32'h11223344};
        vecs[2] = '{1'b0, 1'b1, SIZE_B, 32'h80000003, 32'h000000AA, 32'h55555555, 1, 1, 32'h11223344};
        vecs[3] = '{1'b0, 1'b1, SIZE_H, 32'h80000006, 32'h0000BEEF, 32'h0,        0, 1, 32'h11223344};
        vecs[4] = '{1'b1, 1'b0, SIZE_W, 32'hBFC00004, 32'h0,        32'h8C430004, 0, 0, 32'h8C430004};
        vecs[5] = '{1'b0, 1'b0, SIZE_H, 32'h80000020, 32'h0,        32'h0000ABCD, 1, 0, 32'h0000ABCD};
        vecs[6] = '{1'b0, 1'b1, SIZE_W, 32'h80000024, 32'h12345678, 32'h0,        0, 0, 32'h0000ABCD};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("rst_idmem", 32'(idmem), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_vec(i, vecs[i]);
            if (vecs[i].is_inst) exp_i = vecs[i].exp_rdata;
            else if (!vecs[i].wr) exp_d = vecs[i].exp_rdata;
        end

        // Simultaneous requests: data goes first
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC00008;
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h80000010;
        @(negedge clk); #1;
        chk("arb_first_addr", bus_addr, 32'h80000010);
        chk("arb_first_wr", 32'(bus_wr), 32'd0);
        chk("arb_imem_busy", 32'(idmem.imem_busy), 32'd1);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE0001;
        #1;
        chk("arb_dmem_busy", 32'(idmem.dmem_busy), 32'd0);
        chk("arb_data_rdata", data_rdata, 32'hCAFE0001);
        chk("arb_imem_busy", 32'(idmem.imem_busy), 32'd1);
        exp_d = 32'hCAFE0001;
        @(negedge clk);
        bus_data_ok = 1'b0; data_req = 1'b0;
        #1;
        chk("arb_gap_req", 32'(bus_req), 32'd0);
        chk("arb_imem_busy", 32'(idmem.imem_busy), 32'd1);
        @(negedge clk); #1;
        chk("arb_second_req", 32'(bus_req), 32'd1);
        chk("arb_second_addr", bus_addr, 32'hBFC00008);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h00000001;
        #1;
        chk("arb_inst_rdata", inst_rdata, 32'h00000001);
        exp_i = 32'h00000001;
        @(negedge clk);
        bus_data_ok = 1'b0; inst_req = 1'b0;
        $display("txn arb data=80000010 then inst=bfc00008");

        // Flush during I_DATA discards the response
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC00100;
        @(negedge clk); #1;
        chk("fl_req", 32'(bus_req), 32'd1);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; flush_f = 1'b1; inst_addr = 32'hBFC00200;
        #1;
        chk("fl_imem_busy", 32'(idmem.imem_busy), 32'd1);
        @(negedge clk);
        flush_f = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        chk("fl_busy_at_ok", 32'(idmem.imem_busy), 32'd1);
        chk("fl_not_delivered", inst_rdata, exp_i);
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        chk("fl_busy_after", 32'(idmem.imem_busy), 32'd1);
        chk("fl_gap_req", 32'(bus_req), 32'd0);
        @(negedge clk); #1;
        chk("fl_new_req", 32'(bus_req), 32'd1);
        chk("fl_new_addr", bus_addr, 32'hBFC00200);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h00000013;
        #1;
        chk("fl_new_rdata", inst_rdata, 32'h00000013);
        exp_i = 32'h00000013;
        @(negedge clk);
        bus_data_ok = 1'b0; inst_req = 1'b0;
        $display("txn flush old=bfc00100 new=bfc00200");

        // Completion under stall_f: held response, no re-issue
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC00300; stall_f = 1'b1;
        b0 = bursts;
        @(negedge clk);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C1D8000;
        #1;
        chk("st_busy_at_ok", 32'(idmem.imem_busy), 32'd0);
        @(negedge clk);
        bus_data_ok = 1'b0; bus_rdata = 32'h0BADF00D;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("st_busy_held", 32'(idmem.imem_busy), 32'd0);
            chk("st_rdata_held", inst_rdata, 32'h3C1D8000);
            chk("st_no_req", 32'(bus_req), 32'd0);
            @(negedge clk);
        end
        stall_f = 1'b0;
        #1;
        chk("st_release_busy", 32'(idmem.imem_busy), 32'd0);
        @(negedge clk); #1;
        chk("st_hold_cleared", 32'(idmem.imem_busy), 32'd1);
        inst_req = 1'b0;
        chk("st_one_burst", 32'(bursts), 32'(b0 + 1));
        exp_i = 32'h3C1D8000;
        $display("txn stalled inst=bfc00300 rdata=3c1d8000");

        // Reset asserted in D_DATA abandons the access
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h80000040;
        @(negedge clk);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; resetn = 1'b0;
        #1;
        chk("rs_bus_req", 32'(bus_req), 32'd0);
        chk("rs_bus_addr", bus_addr, 32'd0);
        chk("rs_inst_rdata", inst_rdata, 32'd0);
        chk("rs_dmem_busy", 32'(idmem.dmem_busy), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rs_idle", 32'(bus_req), 32'd0);
        @(negedge clk); #1;
        chk("rs_reissue", 32'(bus_req), 32'd1);
        chk("rs_reissue_addr", bus_addr, 32'h80000040);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h600DD00D;
        #1;
        chk("rs_dmem_drop", 32'(idmem.dmem_busy), 32'd0);
        chk("rs_data_rdata", data_rdata, 32'h600DD00D);
        @(negedge clk);
        bus_data_ok = 1'b0; data_req = 1'b0;
        $display("txn reset-abandon addr=80000040 reissued");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
